// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall / branch flush control with saturating event counters
module hazard_control_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_DEPTH  = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Branch,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_Rt_Reg,
    input  logic [REG_W-1:0] IF_ID_Rs_Reg,
    input  logic [REG_W-1:0] IF_ID_Rt_Reg,
    input  logic             Cnt_Clear,
    output logic             Stall,
    output logic             Block_PC_Write,
    output logic             Block_IF_ID_Write,
    output logic             Flush,
    output logic [CNT_W-1:0] Stall_Events,
    output logic [CNT_W-1:0] Flush_Events
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0]       REM_INIT = 2'(LOAD_LATENCY - 1);

    state_t           state_q, state_d;
    logic [1:0]       remaining_q, remaining_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic stall_entry;
    logic flush_entry;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        hazard = ID_EX_MemRead && (ID_EX_Rt_Reg != '0) &&
                 ((ID_EX_Rt_Reg == IF_ID_Rs_Reg) || (ID_EX_Rt_Reg == IF_ID_Rt_Reg));
    end

    // A branch coinciding with a hazard is dropped: ID is held and re-presents it later.
    always_comb begin
        stall_entry = (state_q == IDLE) && hazard;
        flush_entry = (state_q == IDLE) && !hazard && Branch;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (hazard) begin
                    if (LOAD_LATENCY > 1) begin
                        state_d     = STALL;
                        remaining_d = REM_INIT;
                    end
                end else if (Branch && (FLUSH_DEPTH == 2)) begin
                    state_d = FLUSH;
                end
            end
            STALL: begin
                if (remaining_q == 2'd1) begin
                    state_d     = IDLE;
                    remaining_d = 2'd0;
                end else begin
                    remaining_d = remaining_q - 2'd1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                remaining_d = 2'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Cnt_Clear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_entry && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_entry && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        Stall             = (state_q == STALL) || stall_entry;
        Block_PC_Write    = Stall;
        Block_IF_ID_Write = Stall;
        Flush             = (state_q == FLUSH) || flush_entry;
        Stall_Events      = stall_cnt_q;
        Flush_Events      = flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized and directed checks of hazard_control_unit against a cycle-count model
module tb_hazard_control_unit;

    localparam int REG_W = 5;
    localparam int LL    = 3;
    localparam int FD    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic             clk;
    logic             reset;
    logic             br;
    logic             mr;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             clr;
    logic             stall, bpc, bifid, flush;
    logic [CW-1:0]    s_ev, f_ev;

    int n_pass  = 0;
    int n_total = 0;
    int cmp_en  = 0;

    int m_stall_left = 0;
    int m_flush_left = 0;
    int m_scnt       = 0;
    int m_fcnt       = 0;

    logic e_hz, e_idle, e_stall, e_flush;

    hazard_control_unit #(
        .REG_W(REG_W), .LOAD_LATENCY(LL), .FLUSH_DEPTH(FD), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .Branch(br), .ID_EX_MemRead(mr),
        .ID_EX_Rt_Reg(ex_rt), .IF_ID_Rs_Reg(id_rs), .IF_ID_Rt_Reg(id_rt),
        .Cnt_Clear(clr), .Stall(stall), .Block_PC_Write(bpc),
        .Block_IF_ID_Write(bifid), .Flush(flush),
        .Stall_Events(s_ev), .Flush_Events(f_ev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        e_hz    = mr && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        e_idle  = (m_stall_left == 0) && (m_flush_left == 0);
        e_stall = (m_stall_left > 0) || (e_idle && e_hz);
        e_flush = (m_flush_left > 0) || (e_idle && !e_hz && br);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Model: cycles of forced stall/flush still owed after the accepting cycle.
    task automatic model_update();
        if (!reset) begin
            m_stall_left = 0; m_flush_left = 0; m_scnt = 0; m_fcnt = 0;
            return;
        end
        if (clr) begin
            m_scnt = 0; m_fcnt = 0;
        end else if (e_idle && e_hz) begin
            m_scnt = sat_inc(m_scnt);
        end else if (e_idle && br) begin
            m_fcnt = sat_inc(m_fcnt);
        end
        if (m_stall_left > 0)      m_stall_left--;
        else if (m_flush_left > 0) m_flush_left--;
        else if (e_hz)             m_stall_left = LL - 1;
        else if (br)               m_flush_left = FD - 1;
    endtask

    task automatic step(input logic b, input logic m, input int ert, input int rs,
                        input int rt, input logic c, input logic r);
        @(posedge clk);
        model_update();
        #1;
        br = b; mr = m; ex_rt = REG_W'(ert); id_rs = REG_W'(rs); id_rt = REG_W'(rt);
        clr = c; reset = r;
        if (!r) begin
            m_stall_left = 0; m_flush_left = 0; m_scnt = 0; m_fcnt = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (cmp_en != 0) begin
            chk("stall", int'(stall), int'(e_stall));
            chk("block_pc", int'(bpc), int'(e_stall));
            chk("block_ifid", int'(bifid), int'(e_stall));
            chk("flush", int'(flush), int'(e_flush));
            chk("stall_events", int'(s_ev), m_scnt);
            chk("flush_events", int'(f_ev), m_fcnt);
            chk("stall_flush_exclusive", int'(stall && flush), 0);
        end
    end

    initial begin
        int cnt;
        reset = 1'b0; br = 1'b0; mr = 1'b0; clr = 1'b0;
        ex_rt = '0; id_rs = '0; id_rt = '0;
        cmp_en = 1;

        #2;
        chk("reset_stall", int'(stall), 0);
        chk("reset_flush", int'(flush), 0);
        chk("reset_sev", int'(s_ev), 0);
        chk("reset_fev", int'(f_ev), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);

        step(0, 1, 8, 8, 0, 0, 1);
        chk("load_use_stall_first", int'(stall), 1);
        cnt = int'(stall);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            cnt += int'(stall);
        end
        chk("load_use_stall_cycles", cnt, 3);
        chk("load_use_stall_events", int'(s_ev), 1);

        step(0, 1, 0, 0, 0, 0, 1);
        chk("reg0_no_stall", int'(stall), 0);
        idle(1);
        chk("reg0_events_same", int'(s_ev), 1);

        step(1, 0, 0, 0, 0, 0, 1);
        chk("branch_flush_1", int'(flush), 1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("branch_flush_2", int'(flush), 1);
        idle(1);
        chk("branch_flush_end", int'(flush), 0);
        chk("branch_flush_events", int'(f_ev), 1);

        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 1, 5, 5, 0, 0, 1);
        chk("both_stall", int'(stall), 1);
        chk("both_no_flush", int'(flush), 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("late_branch_flush", int'(flush), 1);
        chk("late_branch_no_stall", int'(stall), 0);
        idle(2);
        chk("late_branch_fev", int'(f_ev), 1);
        chk("late_branch_sev", int'(s_ev), 1);

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 9, 0, 9, 0, 1);
            idle(LL - 1);
        end
        idle(1);
        chk("stall_events_saturate", int'(s_ev), 15);
        step(0, 1, 9, 9, 0, 1, 1);
        idle(3);
        chk("clear_beats_hazard", int'(s_ev), 0);

        step(0, 1, 7, 7, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_mid_stall", int'(stall), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("post_reset_stall", int'(stall), 0);
        chk("post_reset_sev", int'(s_ev), 0);
        idle(2);
        chk("post_reset_stall_later", int'(stall), 0);
        chk("post_reset_fev", int'(f_ev), 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) != 0));
        end
        idle(2);
        cmp_en = 0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
